// File: rtl/risc_mem_responder.sv
// risc_mem_responder: instruction/data word arrays for the RISC core
// plus a byte-serial loader that fills them while the core is held.
module risc_mem_responder #(
    parameter int          IMEM_DEPTH = 16,
    parameter int          DMEM_DEPTH = 16,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_wdata,
    input  logic        ram_we,
    output logic [31:0] ram_rdata,
    input  logic        load_start,
    input  logic        load_target,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_go,
    output logic        load_ready,
    output logic        load_overflow,
    output logic        core_hold
);

    localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        HOLD,
        LOAD,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ptr;
    logic [1:0]  bcnt;
    logic [23:0] shreg;
    logic        tgt;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    logic        accept;
    logic        word_done;
    logic        in_range;
    logic        imem_wr;
    logic        dmem_ld_wr;
    logic        core_wr;
    logic [31:0] word;

    // next state; a restart outranks load_go
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            load_start:             state_nxt = LOAD;
            !load_start && load_go: state_nxt = RUN;
            default:                state_nxt = state;
        endcase
    end

    // loader datapath strobes; a byte arriving with load_start is dropped
    always_comb begin
        accept     = (state == LOAD) && load_valid && !load_start;
        word_done  = accept && (bcnt == 2'd3);
        in_range   = tgt ? (ptr < 32'(DMEM_DEPTH))
                         : (ptr < 32'(IMEM_DEPTH));
        imem_wr    = word_done && in_range && !tgt;
        dmem_ld_wr = word_done && in_range && tgt;
        core_wr    = (state == RUN) && ram_we
                     && (ram_addr < 32'(DMEM_DEPTH));
        word       = {load_byte, shreg};
    end

    // state, loader pointers and registered status decodes
    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= HOLD;
            ptr           <= '0;
            bcnt          <= '0;
            shreg         <= '0;
            tgt           <= 1'b0;
            load_overflow <= 1'b0;
            core_hold     <= 1'b1;
            load_ready    <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_hold  <= (state_nxt != RUN);
            load_ready <= (state_nxt == LOAD);
            if (load_start) begin
                ptr           <= '0;
                bcnt          <= '0;
                tgt           <= load_target;
                load_overflow <= 1'b0;
            end else begin
                if (accept) begin
                    if (word_done) begin
                        bcnt <= '0;
                        if (in_range) ptr <= ptr + 32'd1;
                        else load_overflow <= 1'b1;
                    end else begin
                        shreg[8*bcnt +: 8] <= load_byte;
                        bcnt <= bcnt + 2'd1;
                    end
                end
                if (load_go) bcnt <= '0;
            end
        end
    end

    // instruction array: written only by the loader, never cleared
    always_ff @(posedge clk) begin
        if (!clr && imem_wr) imem[ptr[IW-1:0]] <= word;
    end

    // data array: loader words in LOAD, core stores in RUN
    always_ff @(posedge clk) begin
        if (!clr && dmem_ld_wr) dmem[ptr[DW-1:0]] <= word;
        else if (!clr && core_wr) dmem[ram_addr[DW-1:0]] <= ram_wdata;
    end

    // combinational reads with full-address range checks
    always_comb begin
        imem_data = NOP_WORD;
        ram_rdata = '0;
        if (imem_addr < 32'(IMEM_DEPTH)) imem_data = imem[imem_addr[IW-1:0]];
        if (ram_addr < 32'(DMEM_DEPTH)) ram_rdata = dmem[ram_addr[DW-1:0]];
    end

endmodule
